alu_seq: RTL
============

# alu_seq

Command-driven sequencer that acts as the initiator for the team's 8-bit combinational `alu`. It accepts commands over a valid/ready handshake and reads operands from a 4×8 register file. It drives the ALU's `A`/`B`/`S`/`C_in` ports and captures `D`/`C_out`/`z`. Single-bit ALU shifts are iterated to give multi-bit shifts, and each result is written back with flags and a one-cycle result strobe.

## Interface
- `W`, 8, datapath width; only 8 is supported (matches `alu`).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_ld` in 1: 1 = load `cmd_imm` into `rd`; 0 = ALU op.
- `cmd_op` in 4: ALU select, driven to `S`.
  - `[3:2]` 00 = arith, 01 = logic, 10 = shift right, 11 = shift left.
  - `[1:0]` = sub-op; arith 00 is A+B+C_in.
- `cmd_rd`, `cmd_ra`, `cmd_rb` in 2 each: destination and source register indices.
- `cmd_cnt` in 3: shift count for shift ops; 0 is treated as 1; ignored otherwise.
- `cmd_cin` in 1: carry-in for arith ops.
- `cmd_imm` in 8: immediate for `cmd_ld`.
- `alu_a`, `alu_b` out 8; `alu_s` out 4; `alu_cin` out 1: to the ALU.
- `alu_d` in 8; `alu_cout` in 1; `alu_z` in 1: from the ALU.
- `res_valid` out 1: one-cycle writeback strobe.
- `res_data` out 8; `res_c` out 1; `res_z` out 1: written value and flags.

## Operation
- Handshake: a command transfers on the `clk` edge where `cmd_valid & cmd_ready`. Command fields are latched at that edge; inputs are ignored otherwise.
- States:
  - IDLE: `cmd_ready`=1. On transfer, go to WB if `cmd_ld`, else EXEC.
  - EXEC: ALU driven from registered operands.
    - Arith or logic: one cycle, capture `alu_d`, go to WB.
    - Shift: `remaining` is loaded with max(`cmd_cnt`,1). Each EXEC cycle captures `alu_d` as the next `alu_a` and decrements `remaining`; at 1 go to WB.
  - WB: write the result to `rd`, update the flags, pulse `res_valid`, then return to IDLE.
- ALU drive:
  - `alu_a` = `r[ra]` on the first EXEC cycle, then the fed-back value.
  - `alu_b` = `r[rb]`; `alu_s` = `cmd_op`; `alu_cin` = `cmd_cin`.
  - Outside EXEC, all ALU outputs are 0.
- Flags:
  - Arith: `c` = `alu_cout`, `z` = `alu_z`.
  - Logic: `c` = 0, `z` = (result==0).
  - Shift right: `c` = last bit shifted out (A[0] of the final EXEC cycle). Shift left: `c` = A[7] of the final EXEC cycle. `z` = (result==0).
  - Load: `c` unchanged, `z` = (imm==0).
- `rd` may equal `ra` or `rb`. Operands are read in EXEC before the WB write, so no hazard.
- Reset (asynchronous, including mid-EXEC): state = IDLE, `r0`..`r3` = 0, flags = 0, `res_valid` = 0, `res_data` = 0, `res_c` = 0, `res_z` = 0. `cmd_ready` is 1 after reset; an in-flight command is dropped without a strobe.

## Timing
- Load: accepted at cycle 0, `res_valid` at cycle 1, `cmd_ready` high again at cycle 2.
- Arith/logic: EXEC at cycle 1, `res_valid` at cycle 2, next accept at cycle 3 at the earliest.
- Shift by n (n = 1..7): EXEC at cycles 1..n, `res_valid` at cycle n+1.
- `res_*` outputs are registered; they hold their value after the strobe until the next WB.
- The ALU is purely combinational; its outputs are sampled in the same EXEC cycle in which it is driven.

## Configuration
- `ALU_SEQ_FWD_EN` defined:
  - `cmd_ready` is also 1 in WB, so a new command can be accepted in the WB cycle.
  - If the new `ra`/`rb` equals the `rd` being written, the WB value is forwarded.
  - Back-to-back arith throughput becomes 1 command per 2 cycles.
- `ALU_SEQ_FWD_EN` undefined: `cmd_ready` = 1 only in IDLE; no forwarding logic.

## Test plan
- Reset mid-shift:
  - Assert `rst_n`=0 during EXEC of a shift by 5.
  - Required: outputs and registers go to 0 immediately; no `res_valid`; `cmd_ready`=1 after release.
- Load then add:
  - ld r1=0x3C, ld r2=0xC4, then arith op 0000 with rd=r3, ra=r1, rb=r2, cin=0.
  - Required: `res_data`=0x00, `res_c`=1, `res_z`=1, `res_valid` at cycle 2 after acceptance.
- Shift right by 3:
  - r0=0x96, op 1000, cnt=3, rd=r0.
  - Required: 3 EXEC cycles with `alu_a` = 0x96, 0x4B, 0x25; `res_data`=0x12, `res_c`=1; r0 = 0x12.
- Shift left, count 0:
  - r1=0x81, op 1100, cnt=0.
  - Required: exactly one EXEC cycle; `res_data`=0x02, `res_c`=1, `res_z`=0.
- Backpressure:
  - Hold `cmd_valid`=1 with varying fields during EXEC.
  - Required: fields are not sampled; the second command is accepted only when `cmd_ready`=1; each accepted command gives exactly one `res_valid`.
- With `ALU_SEQ_FWD_EN`:
  - ld r1=0x05, then immediately add ra=r1, rb=r1 accepted in the WB cycle.
  - Required: `res_data`=0x0A.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an external 8-bit combinational ALU.
// Commands arrive over a valid/ready handshake. Operands come from a 4x8
// register file. Single-bit ALU shifts are iterated into multi-bit shifts.
// Every command ends with one write-back cycle, in which res_valid pulses.
// Optional feature macro: ALU_SEQ_FWD_EN. When it is defined, the block
// accepts a command during write-back and forwards the value being written.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_ld,
    input  logic [3:0]   cmd_op,
    input  logic [1:0]   cmd_rd,
    input  logic [1:0]   cmd_ra,
    input  logic [1:0]   cmd_rb,
    input  logic [2:0]   cmd_cnt,
    input  logic         cmd_cin,
    input  logic [W-1:0] cmd_imm,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_s,
    output logic         alu_cin,
    input  logic [W-1:0] alu_d,
    input  logic         alu_cout,
    input  logic         alu_z,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_c,
    output logic         res_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   r_reg [4];
    logic [3:0]     op_reg;
    logic [1:0]     rd_reg;
    logic           cin_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2:0]     remaining_reg;
    logic           res_valid_reg;
    logic [W-1:0]   res_data_reg;
    logic           res_c_reg;
    logic           res_z_reg;
    logic [W-1:0]   ra_val, rb_val;
    logic           accept;
    logic           exec_done;

    assign accept = cmd_valid & cmd_ready;
    // A shift finishes when its last single-bit step runs. Arith and logic finish in one cycle.
    assign exec_done = !op_reg[3] || (remaining_reg == 3'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake ready
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = cmd_ld ? WB : EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_next = WB;
                end
            end
            WB: begin
`ifdef ALU_SEQ_FWD_EN
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = cmd_ld ? WB : EXEC;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand read. The register file write lands at the end of WB, so a
    // command accepted during WB takes the pending value when it is forwarded.
    always_comb begin
        ra_val = r_reg[cmd_ra];
        rb_val = r_reg[cmd_rb];
`ifdef ALU_SEQ_FWD_EN
        if (state_reg == WB && rd_reg == cmd_ra) begin
            ra_val = res_data_reg;
        end
        if (state_reg == WB && rd_reg == cmd_rb) begin
            rb_val = res_data_reg;
        end
`endif
    end

    // Register file write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_reg[i] <= '0;
            end
        end else if (state_reg == WB) begin
            r_reg[rd_reg] <= res_data_reg;
        end
    end

    // Command latch, shift iteration and result/flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= '0;
            rd_reg        <= '0;
            cin_reg       <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            remaining_reg <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_c_reg     <= 1'b0;
            res_z_reg     <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            if (accept) begin
                op_reg        <= cmd_op;
                rd_reg        <= cmd_rd;
                cin_reg       <= cmd_cin;
                a_reg         <= ra_val;
                b_reg         <= rb_val;
                remaining_reg <= (cmd_cnt == 3'd0) ? 3'd1 : cmd_cnt;
                if (cmd_ld) begin
                    // A load leaves the carry flag untouched.
                    res_data_reg  <= cmd_imm;
                    res_z_reg     <= (cmd_imm == '0);
                    res_valid_reg <= 1'b1;
                end
            end
            if (state_reg == EXEC) begin
                if (op_reg[3]) begin
                    // Shift: feed the ALU output back as the next A operand.
                    a_reg         <= alu_d;
                    remaining_reg <= remaining_reg - 3'd1;
                    if (exec_done) begin
                        res_data_reg  <= alu_d;
                        res_c_reg     <= op_reg[2] ? a_reg[W-1] : a_reg[0];
                        res_z_reg     <= (alu_d == '0);
                        res_valid_reg <= 1'b1;
                    end
                end else if (op_reg[2]) begin
                    res_data_reg  <= alu_d;
                    res_c_reg     <= 1'b0;
                    res_z_reg     <= (alu_d == '0);
                    res_valid_reg <= 1'b1;
                end else begin
                    res_data_reg  <= alu_d;
                    res_c_reg     <= alu_cout;
                    res_z_reg     <= alu_z;
                    res_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign alu_a     = (state_reg == EXEC) ? a_reg   : '0;
    assign alu_b     = (state_reg == EXEC) ? b_reg   : '0;
    assign alu_s     = (state_reg == EXEC) ? op_reg  : 4'd0;
    assign alu_cin   = (state_reg == EXEC) ? cin_reg : 1'b0;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_c     = res_c_reg;
    assign res_z     = res_z_reg;

endmodule
